// File: rtl/qam_demod_pkg.sv
// Shared widths, symbol codes and small arithmetic helpers for the QPSK demodulator.
// Accumulator width covers 128 full-scale products, so sums never wrap.
package qam_demod_pkg;

    localparam int SAMPLE_W   = 9;
    localparam int PHASE_W    = 7;
    localparam int SYMBOL_LEN = 128;
    localparam int PROD_W     = 18;
    localparam int ACC_W      = PROD_W + PHASE_W;
    localparam int ENERGY_W   = ACC_W + 1;

    localparam logic [PHASE_W-1:0] PHASE_FIRST = '0;
    localparam logic [PHASE_W-1:0] PHASE_LAST  = PHASE_W'(SYMBOL_LEN - 1);

    // Symbol codes named by the signs of the I and Q correlations.
    localparam logic [1:0] SYM_PI_NQ = 2'b00;
    localparam logic [1:0] SYM_PI_PQ = 2'b01;
    localparam logic [1:0] SYM_NI_PQ = 2'b11;
    localparam logic [1:0] SYM_NI_NQ = 2'b10;

    function automatic logic [ACC_W-1:0] abs_acc(input logic signed [ACC_W-1:0] v);
        return v[ACC_W-1] ? ACC_W'(-v) : ACC_W'(v);
    endfunction

    // A zero Q correlation falls on the negative-Q side.
    function automatic logic [1:0] decide_symbol(input logic signed [ACC_W-1:0] i_sum,
                                                 input logic signed [ACC_W-1:0] q_sum);
        logic neg_i;
        logic pos_q;
        neg_i = i_sum[ACC_W-1];
        pos_q = (q_sum > 0);
        if (!neg_i && !pos_q)
            return SYM_PI_NQ;
        else if (!neg_i && pos_q)
            return SYM_PI_PQ;
        else if (neg_i && pos_q)
            return SYM_NI_PQ;
        else
            return SYM_NI_NQ;
    endfunction

endpackage

// File: rtl/qam_correlator.sv
// One correlator arm: registered sample x reference product feeding a load/accumulate register.
// sum_o is the running total including the product currently held in the pipeline.
module qam_correlator
    import qam_demod_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic [SAMPLE_W-1:0] sample_i,
    input  logic [SAMPLE_W-1:0] ref_i,
    input  logic                first_i,
    input  logic                clear_i,
    output logic [ACC_W-1:0]    sum_o
);

    logic signed [PROD_W-1:0] prod_d;
    logic signed [PROD_W-1:0] prod_q;
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [ACC_W-1:0]  sum;
    logic signed [ACC_W-1:0]  acc_d;
    logic signed [ACC_W-1:0]  acc_q;

    assign prod_d   = PROD_W'($signed(sample_i)) * PROD_W'($signed(ref_i));
    assign prod_ext = {{(ACC_W - PROD_W){prod_q[PROD_W-1]}}, prod_q};

    // A first tag starts a fresh symbol by loading instead of adding.
    always_comb begin
        sum   = first_i ? prod_ext : (acc_q + prod_ext);
        acc_d = clear_i ? '0 : sum;
    end

    assign sum_o = sum;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prod_q <= '0;
            acc_q  <= '0;
        end else begin
            prod_q <= prod_d;
            acc_q  <= acc_d;
        end
    end

endmodule

// File: rtl/qam_demod.sv
// Coherent QPSK demodulator: phase counter driving the sin/cos LUT, I/Q correlation over
// 128-sample symbols and a registered hard decision gated by a carrier-energy threshold.
module qam_demod
    import qam_demod_pkg::*;
#(
    parameter logic [ACC_W-1:0] THRESH = 25'd100000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                sync,
    input  logic [SAMPLE_W-1:0] demod_in,
    input  logic [SAMPLE_W-1:0] GetSin,
    input  logic [SAMPLE_W-1:0] GetCos,
    output logic [PHASE_W-1:0]  recv_read,
    output logic [1:0]          symbol_out,
    output logic                symbol_valid,
    output logic                carrier
);

    logic [PHASE_W-1:0] phase_d, phase_q;
    logic               armed_d, armed_q;
    logic               first_q, last_q, live_q, sync_q;
    logic               at_first, at_last;
    logic               acc_clear;

    logic [ACC_W-1:0]    i_sum, q_sum;
    logic [ENERGY_W-1:0] energy;
    logic                energy_hit;
    logic                decide;

    logic [1:0] symbol_d, symbol_q;
    logic       valid_d, valid_q;
    logic       carrier_d, carrier_q;

    assign at_first = (phase_q == PHASE_FIRST);
    assign at_last  = (phase_q == PHASE_LAST);

    // armed tracks whether the current sample belongs to an aligned symbol; sync drops
    // alignment for later samples only, so the sample presented with sync stays live.
    always_comb begin
        phase_d = sync ? PHASE_FIRST : phase_q + 1'b1;
        armed_d = sync ? 1'b0 : (armed_q | at_first);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_q <= '0;
            armed_q <= 1'b0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
            live_q  <= 1'b0;
            sync_q  <= 1'b0;
        end else begin
            phase_q <= phase_d;
            armed_q <= armed_d;
            first_q <= at_first;
            last_q  <= at_last;
            live_q  <= armed_q | at_first;
            sync_q  <= sync;
        end
    end

    // Partial sums are discarded once the realigning sample has been consumed.
    assign acc_clear = sync_q | ~live_q;

    qam_correlator u_corr_i (
        .clk      (clk),
        .reset    (reset),
        .sample_i (demod_in),
        .ref_i    (GetCos),
        .first_i  (first_q),
        .clear_i  (acc_clear),
        .sum_o    (i_sum)
    );

    qam_correlator u_corr_q (
        .clk      (clk),
        .reset    (reset),
        .sample_i (demod_in),
        .ref_i    (GetSin),
        .first_i  (first_q),
        .clear_i  (acc_clear),
        .sum_o    (q_sum)
    );

    assign energy     = {1'b0, abs_acc(i_sum)} + {1'b0, abs_acc(q_sum)};
    assign energy_hit = (energy >= {1'b0, THRESH});
    assign decide     = last_q & live_q;

    always_comb begin
        symbol_d  = symbol_q;
        valid_d   = 1'b0;
        carrier_d = carrier_q;
        if (decide) begin
            carrier_d = energy_hit;
            if (energy_hit) begin
                valid_d  = 1'b1;
                symbol_d = decide_symbol(i_sum, q_sum);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            symbol_q  <= '0;
            valid_q   <= 1'b0;
            carrier_q <= 1'b0;
        end else begin
            symbol_q  <= symbol_d;
            valid_q   <= valid_d;
            carrier_q <= carrier_d;
        end
    end

    assign recv_read    = phase_q;
    assign symbol_out   = symbol_q;
    assign symbol_valid = valid_q;
    assign carrier      = carrier_q;

endmodule

// File: tb/tb_qam_demod.sv
// Directed bench for qam_demod: a bench-side QPSK modulator aligned by sync feeds the DUT,
// and strobe times / codes / carrier history are checked against hand-derived values.
module tb_qam_demod;

    // 128 * 255 * 2 * 2 = 130560: a +/-2 input against a +/-255 reference lands exactly on it.
    localparam logic [24:0] TB_THRESH = 25'd130560;
    localparam int HIST = 8192;

    logic       clk = 1'b0;
    logic       reset;
    logic       sync;
    logic [8:0] demod_in;
    logic [8:0] GetSin;
    logic [8:0] GetCos;
    logic [6:0] recv_read;
    logic [1:0] symbol_out;
    logic       symbol_valid;
    logic       carrier;

    int cos_tab [0:127];
    int sin_tab [0:127];
    bit lut_mode = 1'b0;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int tx_ph = 0;

    int         sv_cyc [$];
    logic [1:0] sv_sym [$];
    logic       carr_hist [0:HIST-1];
    logic [1:0] sym_hist  [0:HIST-1];

    qam_demod #(.THRESH(TB_THRESH)) dut (
        .clk          (clk),
        .reset        (reset),
        .sync         (sync),
        .demod_in     (demod_in),
        .GetSin       (GetSin),
        .GetCos       (GetCos),
        .recv_read    (recv_read),
        .symbol_out   (symbol_out),
        .symbol_valid (symbol_valid),
        .carrier      (carrier)
    );

    always #5 clk = ~clk;

    // LUT: amplitude-100 sinusoid, or a constant full-scale reference for the range tests.
    assign GetCos = lut_mode ? 9'h0FF : 9'(cos_tab[recv_read]);
    assign GetSin = lut_mode ? 9'h101 : 9'(sin_tab[recv_read]);

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (cyc < HIST) begin
            carr_hist[cyc] = carrier;
            sym_hist[cyc]  = symbol_out;
        end
        if (symbol_valid) begin
            sv_cyc.push_back(cyc);
            sv_sym.push_back(symbol_out);
        end
    end

    function automatic logic [8:0] tx_sample(input logic [1:0] code, input int ph);
        int si;
        int sq;
        si = code[1] ? -1 : 1;
        sq = code[0] ? 1 : -1;
        return 9'(si * cos_tab[ph] + sq * sin_tab[ph]);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        demod_in = '0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic align(output int t0);
        sync = 1'b1;
        demod_in = '0;
        tick();
        sync = 1'b0;
        tx_ph = 0;
        t0 = cyc;
        sv_cyc.delete();
        sv_sym.delete();
        tests++;
        if (recv_read !== 7'd0) begin
            fails++;
            $display("FAIL align_phase: recv_read=%0d expected 0", recv_read);
        end
    endtask

    task automatic send_symbol(input logic [1:0] code, input bit zero);
        for (int k = 0; k < 128; k++) begin
            if (k == 0) begin
                tests++;
                if (recv_read !== 7'(tx_ph)) begin
                    fails++;
                    $display("FAIL symbol_start_phase: recv_read=%0d expected %0d", recv_read, tx_ph);
                end
            end
            demod_in = zero ? 9'd0 : tx_sample(code, tx_ph);
            tick();
            tx_ph = (tx_ph + 1) % 128;
        end
    endtask

    task automatic send_const(input logic [8:0] v, input int n);
        for (int k = 0; k < n; k++) begin
            demod_in = v;
            tick();
            tx_ph = (tx_ph + 1) % 128;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        sync = 1'b0;
        demod_in = '0;
        tick();
        tick();
        tests += 4;
        if (recv_read !== 7'd0) begin fails++; $display("FAIL reset_phase: got %0d expected 0", recv_read); end
        if (symbol_out !== 2'b00) begin fails++; $display("FAIL reset_symbol: got %b expected 00", symbol_out); end
        if (symbol_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", symbol_valid); end
        if (carrier !== 1'b0) begin fails++; $display("FAIL reset_carrier: got %b expected 0", carrier); end
        reset = 1'b0;
        tick();
        tests++;
        if (recv_read !== 7'd1) begin fails++; $display("FAIL reset_count: got %0d expected 1", recv_read); end
        $display("[TB] reset: phase=%0d sym=%b valid=%b carrier=%b", recv_read, symbol_out, symbol_valid, carrier);
    endtask

    task automatic test_single();
        int t0;
        align(t0);
        send_symbol(2'b01, 1'b0);
        idle(3);
        tests++;
        if (sv_cyc.size() !== 1) begin
            fails++;
            $display("FAIL single_count: got %0d strobes expected 1", sv_cyc.size());
        end else begin
            tests += 3;
            if (sv_cyc[0] !== t0 + 129) begin fails++; $display("FAIL single_time: got %0d expected %0d", sv_cyc[0] - t0, 129); end
            if (sv_sym[0] !== 2'b01) begin fails++; $display("FAIL single_code: got %b expected 01", sv_sym[0]); end
            if (carr_hist[t0 + 129] !== 1'b1) begin fails++; $display("FAIL single_carrier: got %b expected 1", carr_hist[t0 + 129]); end
        end
        tests++;
        if (symbol_valid !== 1'b0) begin fails++; $display("FAIL single_valid_drop: got %b expected 0", symbol_valid); end
        $display("[TB] single: strobes=%0d sym=%b carrier=%b", sv_cyc.size(), symbol_out, carrier);
    endtask

    task automatic test_back_to_back();
        int t0;
        logic [1:0] codes [4];
        codes = '{2'b00, 2'b01, 2'b11, 2'b10};
        align(t0);
        for (int n = 0; n < 4; n++) send_symbol(codes[n], 1'b0);
        idle(3);
        tests++;
        if (sv_cyc.size() !== 4) begin
            fails++;
            $display("FAIL b2b_count: got %0d strobes expected 4", sv_cyc.size());
        end else begin
            for (int n = 0; n < 4; n++) begin
                tests += 2;
                if (sv_cyc[n] !== t0 + 129 + 128 * n) begin
                    fails++;
                    $display("FAIL b2b_time%0d: got %0d expected %0d", n, sv_cyc[n] - t0, 129 + 128 * n);
                end
                if (sv_sym[n] !== codes[n]) begin
                    fails++;
                    $display("FAIL b2b_code%0d: got %b expected %b", n, sv_sym[n], codes[n]);
                end
            end
        end
        $display("[TB] back_to_back: strobes=%0d last_sym=%b", sv_cyc.size(), symbol_out);
    endtask

    task automatic test_rest();
        int t0;
        align(t0);
        send_symbol(2'b01, 1'b0);
        send_symbol(2'b00, 1'b1);
        send_symbol(2'b00, 1'b1);
        send_symbol(2'b10, 1'b0);
        idle(3);
        tests++;
        if (sv_cyc.size() !== 2) begin
            fails++;
            $display("FAIL rest_count: got %0d strobes expected 2", sv_cyc.size());
        end else begin
            tests += 4;
            if (sv_cyc[0] !== t0 + 129) begin fails++; $display("FAIL rest_time0: got %0d expected 129", sv_cyc[0] - t0); end
            if (sv_sym[0] !== 2'b01) begin fails++; $display("FAIL rest_code0: got %b expected 01", sv_sym[0]); end
            if (sv_cyc[1] !== t0 + 513) begin fails++; $display("FAIL rest_time1: got %0d expected 513", sv_cyc[1] - t0); end
            if (sv_sym[1] !== 2'b10) begin fails++; $display("FAIL rest_code1: got %b expected 10", sv_sym[1]); end
        end
        tests += 5;
        if (carr_hist[t0 + 129] !== 1'b1) begin fails++; $display("FAIL rest_carrier_on: got %b expected 1", carr_hist[t0 + 129]); end
        if (carr_hist[t0 + 257] !== 1'b0) begin fails++; $display("FAIL rest_carrier_off1: got %b expected 0", carr_hist[t0 + 257]); end
        if (carr_hist[t0 + 385] !== 1'b0) begin fails++; $display("FAIL rest_carrier_off2: got %b expected 0", carr_hist[t0 + 385]); end
        if (carr_hist[t0 + 513] !== 1'b1) begin fails++; $display("FAIL rest_carrier_back: got %b expected 1", carr_hist[t0 + 513]); end
        if (sym_hist[t0 + 400] !== 2'b01) begin fails++; $display("FAIL rest_hold: got %b expected 01", sym_hist[t0 + 400]); end
        $display("[TB] rest: strobes=%0d sym=%b carrier=%b", sv_cyc.size(), symbol_out, carrier);
    endtask

    task automatic test_sync_mid();
        int t0;
        int t1;
        align(t0);
        for (int k = 0; k < 60; k++) begin
            demod_in = tx_sample(2'b11, tx_ph);
            tick();
            tx_ph++;
        end
        demod_in = tx_sample(2'b11, tx_ph);
        sync = 1'b1;
        tick();
        sync = 1'b0;
        tx_ph = 0;
        t1 = cyc;
        tests++;
        if (recv_read !== 7'd0) begin fails++; $display("FAIL sync_mid_phase: got %0d expected 0", recv_read); end
        send_symbol(2'b10, 1'b0);
        idle(3);
        tests++;
        if (sv_cyc.size() !== 1) begin
            fails++;
            $display("FAIL sync_mid_count: got %0d strobes expected 1", sv_cyc.size());
        end else begin
            tests += 2;
            if (sv_cyc[0] !== t1 + 129) begin fails++; $display("FAIL sync_mid_time: got %0d expected 129", sv_cyc[0] - t1); end
            if (sv_sym[0] !== 2'b10) begin fails++; $display("FAIL sync_mid_code: got %b expected 10", sv_sym[0]); end
        end
        $display("[TB] sync_mid: strobes=%0d sym=%b", sv_cyc.size(), symbol_out);
    endtask

    task automatic test_sync_at_last();
        int t0;
        int t1;
        align(t0);
        for (int k = 0; k < 127; k++) begin
            demod_in = tx_sample(2'b00, tx_ph);
            tick();
            tx_ph++;
        end
        demod_in = tx_sample(2'b00, tx_ph);
        sync = 1'b1;
        tick();
        sync = 1'b0;
        tx_ph = 0;
        t1 = cyc;
        send_symbol(2'b01, 1'b0);
        idle(3);
        tests++;
        if (sv_cyc.size() !== 2) begin
            fails++;
            $display("FAIL sync_last_count: got %0d strobes expected 2", sv_cyc.size());
        end else begin
            tests += 4;
            if (sv_cyc[0] !== t0 + 129) begin fails++; $display("FAIL sync_last_time0: got %0d expected 129", sv_cyc[0] - t0); end
            if (sv_sym[0] !== 2'b00) begin fails++; $display("FAIL sync_last_code0: got %b expected 00", sv_sym[0]); end
            if (sv_cyc[1] !== t1 + 129) begin fails++; $display("FAIL sync_last_time1: got %0d expected 129", sv_cyc[1] - t1); end
            if (sv_sym[1] !== 2'b01) begin fails++; $display("FAIL sync_last_code1: got %b expected 01", sv_sym[1]); end
        end
        $display("[TB] sync_at_last: strobes=%0d sym=%b", sv_cyc.size(), symbol_out);
    endtask

    task automatic test_reset_mid();
        int t0;
        int t1;
        align(t0);
        for (int k = 0; k < 90; k++) begin
            demod_in = tx_sample(2'b11, tx_ph);
            tick();
            tx_ph++;
        end
        reset = 1'b1;
        #1;
        tests += 4;
        if (recv_read !== 7'd0) begin fails++; $display("FAIL rst_mid_phase: got %0d expected 0", recv_read); end
        if (symbol_out !== 2'b00) begin fails++; $display("FAIL rst_mid_symbol: got %b expected 00", symbol_out); end
        if (symbol_valid !== 1'b0) begin fails++; $display("FAIL rst_mid_valid: got %b expected 0", symbol_valid); end
        if (carrier !== 1'b0) begin fails++; $display("FAIL rst_mid_carrier: got %b expected 0", carrier); end
        demod_in = '0;
        tick();
        reset = 1'b0;
        tx_ph = 0;
        t1 = cyc;
        sv_cyc.delete();
        sv_sym.delete();
        send_symbol(2'b11, 1'b0);
        idle(3);
        tests++;
        if (sv_cyc.size() !== 1) begin
            fails++;
            $display("FAIL rst_mid_count: got %0d strobes expected 1", sv_cyc.size());
        end else begin
            tests += 2;
            if (sv_cyc[0] !== t1 + 129) begin fails++; $display("FAIL rst_mid_time: got %0d expected 129", sv_cyc[0] - t1); end
            if (sv_sym[0] !== 2'b11) begin fails++; $display("FAIL rst_mid_code: got %b expected 11", sv_sym[0]); end
        end
        $display("[TB] reset_mid: strobes=%0d sym=%b", sv_cyc.size(), symbol_out);
    endtask

    // Constant references: I = 128*255*d, Q = -128*255*d.
    task automatic test_max_amplitude();
        int t0;
        lut_mode = 1'b1;
        align(t0);
        send_const(9'h101, 128);
        send_const(9'h0FF, 128);
        idle(3);
        tests++;
        if (sv_cyc.size() !== 2) begin
            fails++;
            $display("FAIL max_count: got %0d strobes expected 2", sv_cyc.size());
        end else begin
            tests += 4;
            if (sv_cyc[0] !== t0 + 129) begin fails++; $display("FAIL max_time0: got %0d expected 129", sv_cyc[0] - t0); end
            if (sv_sym[0] !== 2'b11) begin fails++; $display("FAIL max_neg_code: got %b expected 11", sv_sym[0]); end
            if (sv_cyc[1] !== t0 + 257) begin fails++; $display("FAIL max_time1: got %0d expected 257", sv_cyc[1] - t0); end
            if (sv_sym[1] !== 2'b00) begin fails++; $display("FAIL max_pos_code: got %b expected 00", sv_sym[1]); end
        end
        $display("[TB] max_amplitude: strobes=%0d sym=%b", sv_cyc.size(), symbol_out);
    endtask

    task automatic test_threshold();
        int t0;
        lut_mode = 1'b1;
        align(t0);
        send_const(9'h1FE, 128);
        send_const(9'h001, 128);
        idle(3);
        tests++;
        if (sv_cyc.size() !== 1) begin
            fails++;
            $display("FAIL thresh_count: got %0d strobes expected 1", sv_cyc.size());
        end else begin
            tests++;
            if (sv_sym[0] !== 2'b11) begin fails++; $display("FAIL thresh_code: got %b expected 11", sv_sym[0]); end
        end
        tests += 3;
        if (carr_hist[t0 + 129] !== 1'b1) begin fails++; $display("FAIL thresh_equal_carrier: got %b expected 1", carr_hist[t0 + 129]); end
        if (carr_hist[t0 + 257] !== 1'b0) begin fails++; $display("FAIL thresh_below_carrier: got %b expected 0", carr_hist[t0 + 257]); end
        if (sym_hist[t0 + 257] !== 2'b11) begin fails++; $display("FAIL thresh_hold: got %b expected 11", sym_hist[t0 + 257]); end
        lut_mode = 1'b0;
        $display("[TB] threshold: strobes=%0d sym=%b carrier=%b", sv_cyc.size(), symbol_out, carrier);
    endtask

    initial begin
        real pi;
        pi = 3.14159265358979;
        for (int k = 0; k < 128; k++) begin
            cos_tab[k] = $rtoi($floor(100.0 * $cos(2.0 * pi * k / 128.0) + 0.5));
            sin_tab[k] = $rtoi($floor(100.0 * $sin(2.0 * pi * k / 128.0) + 0.5));
        end
        test_reset();
        test_single();
        test_back_to_back();
        test_rest();
        test_sync_mid();
        test_sync_at_last();
        test_reset_mid();
        test_max_amplitude();
        test_threshold();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
